// File: rtl/cpu_pkg.sv
// Shared CPU types: register bus widths, decoded control bundle and the ID/EX latch layout.
package cpu_pkg;
   localparam int REG_W  = 32;
   localparam int REG_AW = 5;

   typedef logic [REG_W-1:0]  RegBus;
   typedef logic [REG_AW-1:0] RegAddrBus;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       alu_src;
      logic [3:0] alu_op;
      logic [2:0] funct3;
   } ctrl_t;

   typedef struct packed {
      logic      valid;
      RegBus     pc;
      RegAddrBus rs1_addr;
      RegAddrBus rs2_addr;
      RegAddrBus rd_addr;
      RegBus     rs1_data;
      RegBus     rs2_data;
      RegBus     imm;
      ctrl_t     ctrl;
   } id_ex_t;

   // A bubble is an all-zero latch: invalid, no control side effects, clean data.
   localparam id_ex_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX boundary bundle: decode-side inputs, EX-stage latch outputs, hold and bubble counters.
interface id_ex_stage_if #(parameter int CNT_W = 32);
   import cpu_pkg::*;

   logic      id_valid;
   RegBus     id_pc;
   RegAddrBus id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic      id_uses_rs1, id_uses_rs2;
   RegBus     id_rs1_data, id_rs2_data, id_imm;
   ctrl_t     id_ctrl;
   logic      ex_flush;
   logic      mem_stall;

   logic      ex_valid;
   RegBus     ex_pc;
   RegAddrBus ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
   RegBus     ex_rs1_data, ex_rs2_data, ex_imm;
   ctrl_t     ex_ctrl;
   logic      id_hold;
   logic [CNT_W-1:0] cnt_load_use, cnt_flush;

   modport master (
      output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr, id_uses_rs1, id_uses_rs2,
             id_rs1_data, id_rs2_data, id_imm, id_ctrl, ex_flush, mem_stall,
      input  ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_ctrl, id_hold, cnt_load_use, cnt_flush
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rd_addr, id_uses_rs1, id_uses_rs2,
             id_rs1_data, id_rs2_data, id_imm, id_ctrl, ex_flush, mem_stall,
      output ex_valid, ex_pc, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, ex_rs1_data, ex_rs2_data,
             ex_imm, ex_ctrl, id_hold, cnt_load_use, cnt_flush
   );
endinterface

// File: rtl/id_ex_hazard.sv
// Load-use detector: a load in EX whose destination feeds a source the ID instruction reads.
module id_ex_hazard
   import cpu_pkg::*;
(
   input  logic      ex_valid,
   input  logic      ex_memread,
   input  RegAddrBus ex_rd_addr,
   input  logic      id_valid,
   input  logic      id_uses_rs1,
   input  logic      id_uses_rs2,
   input  RegAddrBus id_rs1_addr,
   input  RegAddrBus id_rs2_addr,
   output logic      lu
);
   logic rs1_hit, rs2_hit;

   assign rs1_hit = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
   assign rs2_hit = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
   // x0 is hardwired zero, so a load targeting it never produces a dependency.
   assign lu = ex_valid && ex_memread && (ex_rd_addr != '0) && id_valid && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, memory stall and bubble counters.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input logic          clk,
   input logic          rst,
   id_ex_stage_if.slave bus
);
   id_ex_t           ex_q, id_d;
   logic [CNT_W-1:0] cnt_lu_q, cnt_fl_q;
   logic             lu;

   id_ex_hazard u_hazard (
      .ex_valid    (ex_q.valid),
      .ex_memread  (ex_q.ctrl.memread),
      .ex_rd_addr  (ex_q.rd_addr),
      .id_valid    (bus.id_valid),
      .id_uses_rs1 (bus.id_uses_rs1),
      .id_uses_rs2 (bus.id_uses_rs2),
      .id_rs1_addr (bus.id_rs1_addr),
      .id_rs2_addr (bus.id_rs2_addr),
      .lu          (lu)
   );

   always_comb begin
      id_d          = BUBBLE;
      id_d.valid    = bus.id_valid;
      id_d.pc       = bus.id_pc;
      id_d.rs1_addr = bus.id_rs1_addr;
      id_d.rs2_addr = bus.id_rs2_addr;
      id_d.rd_addr  = bus.id_rd_addr;
      id_d.rs1_data = bus.id_rs1_data;
      id_d.rs2_data = bus.id_rs2_data;
      id_d.imm      = bus.id_imm;
      id_d.ctrl     = bus.id_valid ? bus.id_ctrl : '0;
   end

   // A flush kills the ID instruction anyway, so a coincident load-use must not hold the front end.
   assign bus.id_hold = !rst && (bus.mem_stall || (lu && !bus.ex_flush));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q     <= BUBBLE;
         cnt_lu_q <= '0;
         cnt_fl_q <= '0;
      end else if (!bus.mem_stall) begin
         if (bus.ex_flush) begin
            ex_q <= BUBBLE;
            if (!(&cnt_fl_q)) cnt_fl_q <= cnt_fl_q + 1'b1;
         end else if (lu) begin
            ex_q <= BUBBLE;
            if (!(&cnt_lu_q)) cnt_lu_q <= cnt_lu_q + 1'b1;
         end else begin
            ex_q <= id_d;
         end
      end
   end

   assign bus.ex_valid     = ex_q.valid;
   assign bus.ex_pc        = ex_q.pc;
   assign bus.ex_rs1_addr  = ex_q.rs1_addr;
   assign bus.ex_rs2_addr  = ex_q.rs2_addr;
   assign bus.ex_rd_addr   = ex_q.rd_addr;
   assign bus.ex_rs1_data  = ex_q.rs1_data;
   assign bus.ex_rs2_data  = ex_q.rs2_data;
   assign bus.ex_imm       = ex_q.imm;
   assign bus.ex_ctrl      = ex_q.ctrl;
   assign bus.cnt_load_use = cnt_lu_q;
   assign bus.cnt_flush    = cnt_fl_q;
endmodule
